// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: default widths, FSM state
// and owner encodings, SRAM strobe polarities and the write-protect helper.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 4;
    localparam int unsigned SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CAP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I2C = 1'b0,
        OWN_LOC = 1'b1
    } arb_owner_e;

    localparam logic CS_ACTIVE   = 1'b0;
    localparam logic CS_INACTIVE = 1'b1;
    localparam logic RW_READ     = 1'b1;
    localparam logic RW_WRITE    = 1'b0;

    // An I2C access is blocked only when it is a write to a protected address.
    function automatic logic wp_blocked(input logic rw, input logic mask_bit);
        return (rw == RW_WRITE) && mask_bit;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing a single-port synchronous SRAM between the I2C
// slave strobe interface (fixed highest priority, cannot stall) and a local
// req/gnt host port. I2C writes to write-protected addresses are dropped.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned              ADDR_W  = SRAM_ADDR_W,
    parameter int unsigned              DATA_W  = SRAM_DATA_W,
    parameter logic [(2**ADDR_W)-1:0]   WP_MASK = {(2**ADDR_W){1'b0}}
) (
    input  logic              i_ck,
    input  logic              i_rstn,
    // I2C slave side
    input  logic              i2c_cs,
    input  logic              i2c_rw,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_wp_hit,
    output logic              i2c_ovr,
    // local host side
    input  logic              loc_req,
    input  logic              loc_rw,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              loc_rvalid,
    // SRAM side
    output logic              mem_cs,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              i2c_cs_q_r;
    logic              i2c_pend_r;
    logic              i2c_rw_r;
    logic [ADDR_W-1:0] i2c_addr_r;
    logic [DATA_W-1:0] i2c_wdata_r;
    arb_state_e        state_r;
    arb_owner_e        owner_r;

    logic              strobe_start_s;
    logic              wp_block_s;
    logic              pend_clr_s;

    // Strobe falling-edge detect, write-protect decision and pending clear
    always_comb begin
        strobe_start_s = (i2c_cs == CS_ACTIVE) && (i2c_cs_q_r == CS_INACTIVE);
        wp_block_s     = 1'b0;
        pend_clr_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            wp_block_s = i2c_pend_r && wp_blocked(i2c_rw_r, WP_MASK[i2c_addr_r]);
            pend_clr_s = wp_block_s;
        end else if (state_r == ST_ACC) begin
            pend_clr_s = (owner_r == OWN_I2C);
        end else begin
            pend_clr_s = 1'b0;
        end
    end

    // Capture one I2C request per strobe; a strobe while one is pending is
    // dropped and flagged, but the pending request may still retire that edge
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            i2c_cs_q_r  <= CS_INACTIVE;
            i2c_pend_r  <= 1'b0;
            i2c_rw_r    <= RW_READ;
            i2c_addr_r  <= {ADDR_W{1'b0}};
            i2c_wdata_r <= {DATA_W{1'b0}};
            i2c_ovr     <= 1'b0;
        end else begin
            i2c_cs_q_r <= i2c_cs;
            i2c_ovr    <= strobe_start_s && i2c_pend_r;
            if (strobe_start_s && !i2c_pend_r) begin
                i2c_rw_r    <= i2c_rw;
                i2c_addr_r  <= i2c_addr;
                i2c_wdata_r <= i2c_wdata;
                i2c_pend_r  <= 1'b1;
            end else if (pend_clr_s) begin
                i2c_pend_r <= 1'b0;
            end
        end
    end

    // Arbitration FSM; SRAM strobes and handshake pulses are registered on
    // entry to the state they belong to
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_I2C;
            mem_cs     <= CS_INACTIVE;
            mem_rw     <= RW_READ;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            i2c_rdata  <= {DATA_W{1'b0}};
            loc_rdata  <= {DATA_W{1'b0}};
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            i2c_wp_hit <= 1'b0;
        end else begin
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            i2c_wp_hit <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wp_block_s) begin
                        i2c_wp_hit <= 1'b1;
                        mem_cs     <= CS_INACTIVE;
                        state_r    <= ST_IDLE;
                    end else if (i2c_pend_r) begin
                        owner_r   <= OWN_I2C;
                        mem_cs    <= CS_ACTIVE;
                        mem_rw    <= i2c_rw_r;
                        mem_addr  <= i2c_addr_r;
                        mem_wdata <= i2c_wdata_r;
                        state_r   <= ST_ACC;
                    end else if (loc_req) begin
                        owner_r   <= OWN_LOC;
                        mem_cs    <= CS_ACTIVE;
                        mem_rw    <= loc_rw;
                        mem_addr  <= loc_addr;
                        mem_wdata <= loc_wdata;
                        loc_gnt   <= 1'b1;
                        state_r   <= ST_ACC;
                    end else begin
                        mem_cs  <= CS_INACTIVE;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    mem_cs <= CS_INACTIVE;
                    if (mem_rw == RW_READ) begin
                        state_r <= ST_CAP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CAP: begin
                    mem_cs  <= CS_INACTIVE;
                    state_r <= ST_IDLE;
                    if (owner_r == OWN_I2C) begin
                        i2c_rdata <= mem_rdata;
                    end else begin
                        loc_rdata  <= mem_rdata;
                        loc_rvalid <= 1'b1;
                    end
                end
                default: begin
                    mem_cs  <= CS_INACTIVE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM, a
// reference memory image and expected-read scoreboards for both ports.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic       i_ck;
    logic       i_rstn;
    logic       i2c_cs, i2c_rw;
    logic [3:0] i2c_addr;
    logic [7:0] i2c_wdata, i2c_rdata;
    logic       i2c_wp_hit, i2c_ovr;
    logic       loc_req, loc_rw, loc_gnt, loc_rvalid;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata, loc_rdata;
    logic       mem_cs, mem_rw;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] sram    [16];
    logic [7:0] ref_mem [16];
    logic [7:0] loc_exp_q [$];
    logic [7:0] i2c_exp_q [$];

    int cyc         = 0;
    int checks      = 0;
    int errors      = 0;
    int mem_low_cnt = 0;
    int ovr_cnt     = 0;
    int rvalid_cnt  = 0;
    int last_a2_cyc = -100;

    sram_port_arbiter #(.ADDR_W(4), .DATA_W(8), .WP_MASK(16'h0010)) dut (
        .i_ck(i_ck), .i_rstn(i_rstn),
        .i2c_cs(i2c_cs), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
        .i2c_wp_hit(i2c_wp_hit), .i2c_ovr(i2c_ovr),
        .loc_req(loc_req), .loc_rw(loc_rw), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata),
        .loc_rvalid(loc_rvalid),
        .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        i_ck = 1'b0;
        forever #5 i_ck = ~i_ck;
    end

    always @(posedge i_ck) cyc <= cyc + 1;

    // Behavioural single-port SRAM: read data valid the cycle after cs low
    always @(posedge i_ck) begin
        if (mem_cs == 1'b0) begin
            if (mem_rw) mem_rdata <= sram[mem_addr];
            else        sram[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: bus activity counters and local read-data scoreboard
    always @(negedge i_ck) begin
        if (i_rstn) begin
            if (mem_cs == 1'b0) begin
                mem_low_cnt++;
                if (mem_rw && mem_addr == 4'h2) last_a2_cyc = cyc;
            end
            if (i2c_ovr) ovr_cnt++;
            if (loc_rvalid) begin
                rvalid_cnt++;
                check_eq("loc_rvalid_expected", (loc_exp_q.size() != 0), 1);
                if (loc_exp_q.size() != 0) check_eq("loc_rdata", loc_rdata, loc_exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge i_ck);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_mem_cs"}, mem_cs, 1);
        check_eq({pfx, "_mem_rw"}, mem_rw, 1);
        check_eq({pfx, "_mem_addr"}, mem_addr, 0);
        check_eq({pfx, "_mem_wdata"}, mem_wdata, 0);
        check_eq({pfx, "_i2c_rdata"}, i2c_rdata, 0);
        check_eq({pfx, "_loc_rdata"}, loc_rdata, 0);
        check_eq({pfx, "_loc_gnt"}, loc_gnt, 0);
        check_eq({pfx, "_loc_rvalid"}, loc_rvalid, 0);
        check_eq({pfx, "_wp_hit"}, i2c_wp_hit, 0);
        check_eq({pfx, "_ovr"}, i2c_ovr, 0);
    endtask

    task automatic wait_gnt();
        int k;
        k = 0;
        @(negedge i_ck);
        while (!loc_gnt && k < 20) begin
            @(negedge i_ck);
            k++;
        end
        check_eq("loc_gnt_seen", loc_gnt, 1);
    endtask

    // Single local access; returns at the negedge of the grant (ACC) cycle
    task automatic loc_access(input logic rw, input logic [3:0] a, input logic [7:0] d, output int t);
        loc_rw = rw; loc_addr = a; loc_wdata = d; loc_req = 1'b1;
        if (rw) loc_exp_q.push_back(ref_mem[a]);
        else    ref_mem[a] = d;
        wait_gnt();
        t = cyc;
        check_eq("loc_acc_cs", mem_cs, 0);
        check_eq("loc_acc_addr", mem_addr, a);
        check_eq("loc_acc_rw", mem_rw, rw);
        loc_req = 1'b0;
    endtask

    task automatic loc_read_wait(input logic [3:0] a);
        int t;
        loc_access(1'b1, a, 8'h00, t);
        wait_cyc(t + 3);
    endtask

    // Local reads with loc_req held high across grants
    task automatic loc_stream(input int n);
        for (int i = 0; i < n; i++) begin
            loc_rw = 1'b1; loc_addr = 4'(8 + (i % 8)); loc_req = 1'b1;
            loc_exp_q.push_back(ref_mem[loc_addr]);
            wait_gnt();
        end
        loc_req = 1'b0;
    endtask

    // One-cycle I2C strobe; s is the cycle in which i2c_cs is sampled low
    task automatic i2c_op(input logic rw, input logic [3:0] a, input logic [7:0] d, output int s);
        i2c_rw = rw; i2c_addr = a; i2c_wdata = d; i2c_cs = 1'b0;
        s = cyc;
        @(negedge i_ck);
        i2c_cs = 1'b1;
    endtask

    initial begin
        int t, s, s2, cnt0, ovr0, rv0;
        logic [7:0] d;
        i_rstn = 1'b0; i2c_cs = 1'b1; i2c_rw = 1'b1; i2c_addr = 4'h0; i2c_wdata = 8'h00;
        loc_req = 1'b0; loc_rw = 1'b1; loc_addr = 4'h0; loc_wdata = 8'h00;
        repeat (3) @(negedge i_ck);
        check_reset_outputs("rst");
        i_rstn = 1'b1;
        @(negedge i_ck);

        // local write then read back with grant-to-rvalid latency
        loc_access(1'b0, 4'h3, 8'hA5, t);
        loc_access(1'b1, 4'h3, 8'h00, t);
        @(negedge i_ck);
        check_eq("loc_rvalid_t1", loc_rvalid, 0);
        @(negedge i_ck);
        check_eq("loc_rvalid_t2", loc_rvalid, 1);
        check_eq("loc_rdata_a5", loc_rdata, 8'hA5);
        wait_cyc(cyc + 2);

        // preload through the local port
        for (int i = 8; i < 16; i++) begin
            d = 8'hC3 ^ 8'(i * 17);
            loc_access(1'b0, 4'(i), d, t);
        end
        loc_access(1'b0, 4'h2, 8'h3C, t);
        loc_access(1'b0, 4'h5, 8'h55, t);
        loc_access(1'b0, 4'h4, 8'h99, t);
        wait_cyc(cyc + 3);

        // I2C write: mem_cs low exactly two cycles after the strobe
        cnt0 = mem_low_cnt;
        i2c_op(1'b0, 4'h7, 8'h5C, s);
        check_eq("i2c_wr_cs_s1", mem_cs, 1);
        @(negedge i_ck);
        check_eq("i2c_wr_cs_s2", mem_cs, 0);
        check_eq("i2c_wr_rw", mem_rw, 0);
        check_eq("i2c_wr_addr", mem_addr, 4'h7);
        check_eq("i2c_wr_data", mem_wdata, 8'h5C);
        ref_mem[7] = 8'h5C;
        wait_cyc(s + 5);
        check_eq("i2c_wr_one_access", mem_low_cnt - cnt0, 1);

        // I2C read: data visible four cycles after the strobe
        i2c_exp_q.push_back(ref_mem[7]);
        i2c_op(1'b1, 4'h7, 8'h00, s);
        wait_cyc(s + 3);
        check_eq("i2c_rdata_s3_old", i2c_rdata, 8'h00);
        wait_cyc(s + 4);
        check_eq("i2c_rdata_s4", i2c_rdata, i2c_exp_q.pop_front());
        wait_cyc(cyc + 3);

        // contention: continuous local reads vs periodic I2C reads of 0x2
        rv0 = rvalid_cnt;
        fork
            loc_stream(16);
            begin
                int si;
                wait_cyc(cyc + 1);
                repeat (4) begin
                    i2c_exp_q.push_back(ref_mem[2]);
                    i2c_op(1'b1, 4'h2, 8'h00, si);
                    wait_cyc(si + 6);
                    check_eq("cont_i2c_issue_window", (last_a2_cyc >= si + 2 && last_a2_cyc <= si + 4), 1);
                    check_eq("cont_i2c_rdata", i2c_rdata, i2c_exp_q.pop_front());
                    wait_cyc(si + 10);
                end
            end
        join
        wait_cyc(cyc + 4);
        check_eq("cont_rvalid_count", rvalid_cnt - rv0, 16);
        check_eq("cont_loc_q_empty", loc_exp_q.size(), 0);

        // write protect: I2C write to 0x4 blocked, no SRAM cycle
        cnt0 = mem_low_cnt;
        i2c_op(1'b0, 4'h4, 8'h11, s);
        check_eq("wp_hit_s1", i2c_wp_hit, 0);
        @(negedge i_ck);
        check_eq("wp_hit_s2", i2c_wp_hit, 1);
        @(negedge i_ck);
        check_eq("wp_hit_s3", i2c_wp_hit, 0);
        wait_cyc(s + 6);
        check_eq("wp_no_access", mem_low_cnt - cnt0, 0);
        loc_read_wait(4'h4);
        loc_access(1'b0, 4'h4, 8'h77, t);
        loc_read_wait(4'h4);

        // overrun: two strobes one cycle apart starting while a local read is in CAP
        wait_cyc(cyc + 2);
        cnt0 = mem_low_cnt; ovr0 = ovr_cnt;
        loc_access(1'b1, 4'hD, 8'h00, t);
        @(negedge i_ck);
        check_eq("ovr_cap_cs", mem_cs, 1);
        i2c_exp_q.push_back(ref_mem[9]);
        i2c_op(1'b1, 4'h9, 8'h00, s);
        @(negedge i_ck);
        i2c_op(1'b0, 4'hB, 8'hEE, s2);
        check_eq("ovr_pulse", i2c_ovr, 1);
        @(negedge i_ck);
        check_eq("ovr_pulse_end", i2c_ovr, 0);
        check_eq("ovr_first_rdata", i2c_rdata, i2c_exp_q.pop_front());
        wait_cyc(s2 + 6);
        check_eq("ovr_count", ovr_cnt - ovr0, 1);
        check_eq("ovr_accesses", mem_low_cnt - cnt0, 2);
        loc_read_wait(4'hB);

        // reset during ACC of a local write
        loc_rw = 1'b0; loc_addr = 4'h5; loc_wdata = 8'h42; loc_req = 1'b1;
        wait_gnt();
        check_eq("rst_acc_cs_before", mem_cs, 0);
        i_rstn = 1'b0;
        loc_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge i_ck);
        check_eq("midrst_cs_hold", mem_cs, 1);
        i_rstn = 1'b1;
        @(negedge i_ck);
        loc_read_wait(4'h5);
        loc_access(1'b0, 4'h6, 8'h6B, t);
        loc_read_wait(4'h6);

        wait_cyc(cyc + 4);
        check_eq("final_loc_q_empty", loc_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
